// File: rtl/jtgng_dwnld_pkg.sv
// rtl/jtgng_dwnld_pkg.sv - shared state type and byte-mask constants for the ROM downloader
package jtgng_dwnld_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  // prog_mask is active-low: the cleared bit selects the byte lane being written
  localparam logic [1:0] MASK_LO = 2'b10;
  localparam logic [1:0] MASK_HI = 2'b01;

endpackage

// File: rtl/jtgng_dwnld_skid.sv
// rtl/jtgng_dwnld_skid.sv - one-entry holding buffer for SDRAM bytes arriving during a request
module jtgng_dwnld_skid (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic        pop,
  input  logic [21:0] in_addr,
  input  logic [7:0]  in_data,
  input  logic [1:0]  in_mask,
  output logic        valid,
  output logic [21:0] addr,
  output logic [7:0]  data,
  output logic [1:0]  mask,
  output logic        overrun
);

  logic accept;

  // a push is only refused when the entry is occupied and not leaving this cycle
  assign accept = push && (!valid || pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid   <= 1'b0;
      addr    <= '0;
      data    <= '0;
      mask    <= '0;
      overrun <= 1'b0;
    end else begin
      if (accept) begin
        valid <= 1'b1;
        addr  <= in_addr;
        data  <= in_data;
        mask  <= in_mask;
      end else if (pop) begin
        valid <= 1'b0;
      end
      if (push && !accept) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/jtgng_dwnld.sv
// rtl/jtgng_dwnld.sv - byte download to SDRAM word writes and on-chip PROM strobes
module jtgng_dwnld
  import jtgng_dwnld_pkg::*;
#(
  parameter logic [21:0] PROM_START   = 22'h1_8000,
  parameter int          PROM_AW      = 8,
  parameter int          PROM_NUM     = 2,
  parameter logic [21:0] SDRAM_OFFSET = 22'h0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                downloading,
  input  logic [21:0]         ioctl_addr,
  input  logic [7:0]          ioctl_data,
  input  logic                ioctl_wr,
  output logic [21:0]         prog_addr,
  output logic [7:0]          prog_data,
  output logic [1:0]          prog_mask,
  output logic                prog_we,
  input  logic                prog_ack,
  output logic [PROM_NUM-1:0] prom_we,
  output logic [PROM_AW-1:0]  prom_addr,
  output logic [3:0]          prom_data,
  output logic                dwn_done,
  output logic                overrun
);

  state_t state, state_nx;

  logic        dl_q, dl_fall;
  logic        is_sdram, sdram_wr, prom_wr;
  logic        load_io, load_buf, take_ack, push;
  logic [21:0] io_word;
  logic [1:0]  io_mask;
  logic        buf_valid;
  logic [21:0] buf_addr;
  logic [7:0]  buf_data;
  logic [1:0]  buf_mask;
  logic [21:0] prom_off;
  logic [PROM_NUM-1:0] prom_we_nx;

  assign is_sdram = ioctl_addr < PROM_START;
  assign sdram_wr = downloading && ioctl_wr && is_sdram;
  assign prom_wr  = downloading && ioctl_wr && !is_sdram;
  assign dl_fall  = dl_q && !downloading;
  assign io_word  = {1'b0, ioctl_addr[21:1]} + SDRAM_OFFSET;
  assign io_mask  = ioctl_addr[0] ? MASK_HI : MASK_LO;
  assign take_ack = prog_we && prog_ack;
  assign push     = sdram_wr && !load_io;

  jtgng_dwnld_skid u_skid (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (load_buf),
    .in_addr (io_word),
    .in_data (ioctl_data),
    .in_mask (io_mask),
    .valid   (buf_valid),
    .addr    (buf_addr),
    .data    (buf_data),
    .mask    (buf_mask),
    .overrun (overrun)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (dl_fall) begin
          state_nx = FLUSH;
        end else if (load_io || load_buf) begin
          state_nx = REQ;
        end
      end
      REQ: begin
        if (dl_fall) begin
          state_nx = FLUSH;
        end else if (take_ack) begin
          state_nx = IDLE;
        end
      end
      FLUSH: begin
        if (!prog_we && !buf_valid) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // A buffered byte is only issued from a cycle with prog_we low, which keeps
  // at least one idle cycle between back-to-back requests.
  always_comb begin
    load_io  = 1'b0;
    load_buf = 1'b0;
    dwn_done = 1'b0;
    case (state)
      IDLE: begin
        load_buf = buf_valid;
        load_io  = sdram_wr && !buf_valid;
      end
      FLUSH: begin
        load_buf = !prog_we && buf_valid;
        dwn_done = !prog_we && !buf_valid;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dl_q      <= 1'b0;
      prog_we   <= 1'b0;
      prog_addr <= '0;
      prog_data <= '0;
      prog_mask <= '0;
    end else begin
      dl_q <= downloading;
      if (load_buf) begin
        prog_addr <= buf_addr;
        prog_data <= buf_data;
        prog_mask <= buf_mask;
        prog_we   <= 1'b1;
      end else if (load_io) begin
        prog_addr <= io_word;
        prog_data <= ioctl_data;
        prog_mask <= io_mask;
        prog_we   <= 1'b1;
      end else if (take_ack) begin
        prog_we <= 1'b0;
      end
    end
  end

  // PROM bytes beyond the last PROM decode to no strobe and are discarded
  assign prom_off = ioctl_addr - PROM_START;

  always_comb begin
    prom_we_nx = '0;
    for (int i = 0; i < PROM_NUM; i++) begin
      prom_we_nx[i] = prom_wr && ((prom_off >> PROM_AW) == 22'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prom_we   <= '0;
      prom_addr <= '0;
      prom_data <= '0;
    end else begin
      prom_we <= prom_we_nx;
      if (|prom_we_nx) begin
        prom_addr <= ioctl_addr[PROM_AW-1:0];
        prom_data <= ioctl_data[3:0];
      end
    end
  end

endmodule

// File: tb/tb_jtgng_dwnld.sv
// tb/tb_jtgng_dwnld.sv - directed scoreboard bench for the ROM downloader
module tb_jtgng_dwnld;

  localparam logic [21:0] PROM_START_TB = 22'h1_8000;
  localparam logic [21:0] OFFSET_TB     = 22'h0;

  typedef struct packed {
    logic [21:0] addr;
    logic [7:0]  data;
    logic [1:0]  mask;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        downloading;
  logic [21:0] ioctl_addr;
  logic [7:0]  ioctl_data;
  logic        ioctl_wr;
  logic [21:0] prog_addr;
  logic [7:0]  prog_data;
  logic [1:0]  prog_mask;
  logic        prog_we;
  logic        prog_ack;
  logic [1:0]  prom_we;
  logic [7:0]  prom_addr;
  logic [3:0]  prom_data;
  logic        dwn_done;
  logic        overrun;

  int   errors = 0;
  int   checks = 0;
  exp_t sdq[$];

  always #5 clk = ~clk;

  jtgng_dwnld dut (
    .clk         (clk),
    .rst         (rst),
    .downloading (downloading),
    .ioctl_addr  (ioctl_addr),
    .ioctl_data  (ioctl_data),
    .ioctl_wr    (ioctl_wr),
    .prog_addr   (prog_addr),
    .prog_data   (prog_data),
    .prog_mask   (prog_mask),
    .prog_we     (prog_we),
    .prog_ack    (prog_ack),
    .prom_we     (prom_we),
    .prom_addr   (prom_addr),
    .prom_data   (prom_data),
    .dwn_done    (dwn_done),
    .overrun     (overrun)
  );

  function automatic exp_t model(input logic [21:0] a, input logic [7:0] d);
    exp_t e;
    e.addr = (a >> 1) + OFFSET_TB;
    e.data = d;
    e.mask = a[0] ? 2'b01 : 2'b10;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_byte(input logic [21:0] a, input logic [7:0] d, input bit keep);
    if (keep && a < PROM_START_TB) sdq.push_back(model(a, d));
    ioctl_addr = a;
    ioctl_data = d;
    ioctl_wr   = 1'b1;
    tick();
    ioctl_wr   = 1'b0;
  endtask

  // Acknowledge the current request, optionally with a coincident new byte
  task automatic ack_now(input bit with_wr, input logic [21:0] a, input logic [7:0] d);
    exp_t e;
    chk("ack_we_high", 32'(prog_we), 32'(1));
    chk("sb_has_entry", 32'(sdq.size() > 0), 32'(1));
    if (sdq.size() > 0) begin
      e = sdq.pop_front();
      chk("prog_addr", 32'(prog_addr), 32'(e.addr));
      chk("prog_data", 32'(prog_data), 32'(e.data));
      chk("prog_mask", 32'(prog_mask), 32'(e.mask));
    end
    if (with_wr) begin
      sdq.push_back(model(a, d));
      ioctl_addr = a;
      ioctl_data = d;
      ioctl_wr   = 1'b1;
    end
    prog_ack = 1'b1;
    tick();
    prog_ack = 1'b0;
    ioctl_wr = 1'b0;
  endtask

  initial begin
    logic [21:0] burst_a [3];
    logic [7:0]  burst_d [3];

    rst = 1'b1; downloading = 1'b0; ioctl_addr = '0; ioctl_data = '0;
    ioctl_wr = 1'b0; prog_ack = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_prog_we", 32'(prog_we), 32'(0));
    chk("rst_prog_addr", 32'(prog_addr), 32'(0));
    chk("rst_prog_mask", 32'(prog_mask), 32'(0));
    chk("rst_prom_we", 32'(prom_we), 32'(0));
    chk("rst_dwn_done", 32'(dwn_done), 32'(0));
    chk("rst_overrun", 32'(overrun), 32'(0));

    // single SDRAM byte, ack in the third request cycle
    downloading = 1'b1;
    tick();
    wr_byte(22'h000003, 8'hA5, 1'b1);
    chk("t1_we_c0", 32'(prog_we), 32'(1));
    tick();
    chk("t1_we_c1", 32'(prog_we), 32'(1));
    tick();
    ack_now(1'b0, '0, '0);
    chk("t1_we_fall", 32'(prog_we), 32'(0));

    // stray ack while idle is ignored
    prog_ack = 1'b1;
    tick();
    prog_ack = 1'b0;
    chk("stray_ack_we", 32'(prog_we), 32'(0));

    // PROM byte into PROM 1
    wr_byte(PROM_START_TB + 22'h105, 8'h3C, 1'b1);
    chk("prom_we", 32'(prom_we), 32'(2'b10));
    chk("prom_addr", 32'(prom_addr), 32'(8'h05));
    chk("prom_data", 32'(prom_data), 32'(4'hC));
    chk("prom_no_sdram", 32'(prog_we), 32'(0));
    tick();
    chk("prom_we_1cyc", 32'(prom_we), 32'(0));

    // PROM index beyond the last PROM is dropped
    wr_byte(PROM_START_TB + 22'h205, 8'h11, 1'b1);
    chk("prom_oob_we", 32'(prom_we), 32'(0));
    chk("prom_oob_sdram", 32'(prog_we), 32'(0));

    // last SDRAM byte just below the PROM region
    wr_byte(PROM_START_TB - 22'h1, 8'h5A, 1'b1);
    chk("edge_we", 32'(prog_we), 32'(1));
    chk("edge_prom_we", 32'(prom_we), 32'(0));
    ack_now(1'b0, '0, '0);
    tick();

    // three back-to-back bytes with ack withheld
    burst_a[0] = 22'h10; burst_a[1] = 22'h11; burst_a[2] = 22'h12;
    burst_d[0] = 8'h11;  burst_d[1] = 8'h22;  burst_d[2] = 8'h33;
    for (int i = 0; i < 3; i++) begin
      if (i < 2) sdq.push_back(model(burst_a[i], burst_d[i]));
      ioctl_addr = burst_a[i];
      ioctl_data = burst_d[i];
      ioctl_wr   = 1'b1;
      tick();
    end
    ioctl_wr = 1'b0;
    chk("burst_overrun", 32'(overrun), 32'(1));
    chk("burst_we", 32'(prog_we), 32'(1));
    tick();
    ack_now(1'b0, '0, '0);
    chk("burst_gap", 32'(prog_we), 32'(0));
    tick();
    chk("burst_reissue", 32'(prog_we), 32'(1));
    ack_now(1'b0, '0, '0);
    tick();
    chk("burst_third_dropped", 32'(prog_we), 32'(0));

    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("overrun_cleared", 32'(overrun), 32'(0));

    // ack coincident with a new byte
    wr_byte(22'h20, 8'h44, 1'b1);
    tick();
    ack_now(1'b1, 22'h21, 8'h55);
    chk("coinc_gap", 32'(prog_we), 32'(0));
    chk("coinc_overrun0", 32'(overrun), 32'(0));
    tick();
    ack_now(1'b0, '0, '0);
    chk("coinc_overrun1", 32'(overrun), 32'(0));
    tick();

    // download ends while a request is pending
    wr_byte(22'h30, 8'h66, 1'b1);
    downloading = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("flush_no_early_done", 32'(dwn_done), 32'(0));
    end
    ack_now(1'b0, '0, '0);
    chk("flush_done", 32'(dwn_done), 32'(1));
    tick();
    chk("flush_done_once", 32'(dwn_done), 32'(0));
    tick();
    chk("flush_done_once2", 32'(dwn_done), 32'(0));

    // download ends with nothing pending
    downloading = 1'b1;
    tick();
    tick();
    downloading = 1'b0;
    tick();
    chk("idle_done", 32'(dwn_done), 32'(1));
    tick();
    chk("idle_done_once", 32'(dwn_done), 32'(0));

    // reset in the middle of a request
    downloading = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      ioctl_addr = 22'h40 + 22'(i);
      ioctl_data = 8'h70 + 8'(i);
      ioctl_wr   = 1'b1;
      tick();
    end
    ioctl_wr = 1'b0;
    chk("mid_overrun_set", 32'(overrun), 32'(1));
    chk("mid_we_set", 32'(prog_we), 32'(1));
    rst = 1'b1;
    downloading = 1'b0;
    tick();
    rst = 1'b0;
    chk("mid_rst_we", 32'(prog_we), 32'(0));
    chk("mid_rst_addr", 32'(prog_addr), 32'(0));
    chk("mid_rst_data", 32'(prog_data), 32'(0));
    chk("mid_rst_mask", 32'(prog_mask), 32'(0));
    chk("mid_rst_prom", 32'(prom_addr), 32'(0));
    chk("mid_rst_overrun", 32'(overrun), 32'(0));
    for (int i = 0; i < 4; i++) begin
      chk("mid_rst_no_done", 32'(dwn_done), 32'(0));
      chk("mid_rst_no_we", 32'(prog_we), 32'(0));
      tick();
    end

    chk("sb_drained", 32'(sdq.size()), 32'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
